// File: rtl/axi_default_param_pkg.sv
// Shared grid/AXI type definitions for the grid network interfaces.
// Node IDs, AXI IDs and the five AXI channel payloads.
package axi_default_param_pkg;

    typedef logic [3:0] grid_id_t;
    typedef logic [3:0] axi_id_t;

    typedef struct packed {
        axi_id_t     id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } grid_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } grid_w_chan_t;

    typedef struct packed {
        axi_id_t     id;
        logic [1:0]  resp;
    } grid_b_chan_t;

    typedef struct packed {
        axi_id_t     id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } grid_ar_chan_t;

    typedef struct packed {
        axi_id_t     id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } grid_r_chan_t;

endpackage

// File: rtl/axi_grid_sub_ni_if.sv
// Bundle of grid-side and AXI-subordinate-side signals of the subordinate NI.
// The slave modport is the NI's view; master is the surrounding grid/subordinate.
interface axi_grid_sub_ni_if;
    import axi_default_param_pkg::*;

    grid_id_t      grid_aw_did_i, grid_aw_sid_i;
    grid_aw_chan_t grid_aw_chan_i;
    logic          grid_aw_valid_i, grid_aw_ready_o;

    grid_id_t      grid_w_did_i, grid_w_sid_i;
    grid_w_chan_t  grid_w_chan_i;
    logic          grid_w_valid_i, grid_w_ready_o;

    grid_id_t      grid_ar_did_i, grid_ar_sid_i;
    grid_ar_chan_t grid_ar_chan_i;
    logic          grid_ar_valid_i, grid_ar_ready_o;

    grid_id_t      grid_b_did_o, grid_b_sid_o;
    grid_b_chan_t  grid_b_chan_o;
    logic          grid_b_valid_o, grid_b_ready_i;

    grid_id_t      grid_r_did_o, grid_r_sid_o;
    grid_r_chan_t  grid_r_chan_o;
    logic          grid_r_valid_o, grid_r_ready_i;

    grid_aw_chan_t axi_aw_o;
    logic          axi_aw_valid_o, axi_aw_ready_i;
    grid_w_chan_t  axi_w_o;
    logic          axi_w_valid_o, axi_w_ready_i;
    grid_ar_chan_t axi_ar_o;
    logic          axi_ar_valid_o, axi_ar_ready_i;
    grid_b_chan_t  axi_b_i;
    logic          axi_b_valid_i, axi_b_ready_o;
    grid_r_chan_t  axi_r_i;
    logic          axi_r_valid_i, axi_r_ready_o;

    modport slave (
        input  grid_aw_did_i, grid_aw_sid_i, grid_aw_chan_i, grid_aw_valid_i,
        output grid_aw_ready_o,
        input  grid_w_did_i, grid_w_sid_i, grid_w_chan_i, grid_w_valid_i,
        output grid_w_ready_o,
        input  grid_ar_did_i, grid_ar_sid_i, grid_ar_chan_i, grid_ar_valid_i,
        output grid_ar_ready_o,
        output grid_b_did_o, grid_b_sid_o, grid_b_chan_o, grid_b_valid_o,
        input  grid_b_ready_i,
        output grid_r_did_o, grid_r_sid_o, grid_r_chan_o, grid_r_valid_o,
        input  grid_r_ready_i,
        output axi_aw_o, axi_aw_valid_o,
        input  axi_aw_ready_i,
        output axi_w_o, axi_w_valid_o,
        input  axi_w_ready_i,
        output axi_ar_o, axi_ar_valid_o,
        input  axi_ar_ready_i,
        input  axi_b_i, axi_b_valid_i,
        output axi_b_ready_o,
        input  axi_r_i, axi_r_valid_i,
        output axi_r_ready_o
    );

    modport master (
        output grid_aw_did_i, grid_aw_sid_i, grid_aw_chan_i, grid_aw_valid_i,
        input  grid_aw_ready_o,
        output grid_w_did_i, grid_w_sid_i, grid_w_chan_i, grid_w_valid_i,
        input  grid_w_ready_o,
        output grid_ar_did_i, grid_ar_sid_i, grid_ar_chan_i, grid_ar_valid_i,
        input  grid_ar_ready_o,
        input  grid_b_did_o, grid_b_sid_o, grid_b_chan_o, grid_b_valid_o,
        output grid_b_ready_i,
        input  grid_r_did_o, grid_r_sid_o, grid_r_chan_o, grid_r_valid_o,
        output grid_r_ready_i,
        input  axi_aw_o, axi_aw_valid_o,
        output axi_aw_ready_i,
        input  axi_w_o, axi_w_valid_o,
        output axi_w_ready_i,
        input  axi_ar_o, axi_ar_valid_o,
        output axi_ar_ready_i,
        output axi_b_i, axi_b_valid_i,
        input  axi_b_ready_o,
        output axi_r_i, axi_r_valid_i,
        input  axi_r_ready_o
    );

endinterface

// File: rtl/axi_grid_ni_tracker.sv
// Outstanding-transaction tracker: single-ID lock, count, and a FIFO of
// requester node IDs used to address responses back into the grid.
module axi_grid_ni_tracker
    import axi_default_param_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type grid_id_t = axi_default_param_pkg::grid_id_t,
    parameter type axi_id_t  = axi_default_param_pkg::axi_id_t
) (
    input  logic     clk_i,
    input  logic     arst_ni,
    input  logic     push,
    input  grid_id_t push_sid,
    input  axi_id_t  push_id,
    input  logic     pop,
    input  axi_id_t  adm_id,
    output logic     adm,
    output grid_id_t head_sid,
    output logic     nonempty
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    axi_id_t          lock_id_q, lock_id_d;
    grid_id_t         sid_fifo_q [MAX_OUTSTANDING];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Admission looks only at registered state, so a pop in the same cycle
    // never opens a slot early.
    assign adm      = (cnt_q == '0) || ((cnt_q < MAX_CNT) && (adm_id == lock_id_q));
    assign nonempty = (cnt_q != '0);
    assign head_sid = sid_fifo_q[rd_ptr_q];

    always_comb begin
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        lock_id_d = lock_id_q;
        if (push) begin
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            lock_id_d = push_id;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Entries are only read while counted valid, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            sid_fifo_q[wr_ptr_q] <= push_sid;
        end
    end

endmodule

// File: rtl/axi_grid_sub_ni.sv
// Subordinate-side grid NI: strips routing from AW/W/AR and readdresses B/R
// to the requesting node using one tracker per direction.
module axi_grid_sub_ni
    import axi_default_param_pkg::*;
#(
    parameter type grid_id_t      = axi_default_param_pkg::grid_id_t,
    parameter type axi_id_t       = axi_default_param_pkg::axi_id_t,
    parameter type grid_aw_chan_t = axi_default_param_pkg::grid_aw_chan_t,
    parameter type grid_w_chan_t  = axi_default_param_pkg::grid_w_chan_t,
    parameter type grid_b_chan_t  = axi_default_param_pkg::grid_b_chan_t,
    parameter type grid_ar_chan_t = axi_default_param_pkg::grid_ar_chan_t,
    parameter type grid_r_chan_t  = axi_default_param_pkg::grid_r_chan_t,
    parameter grid_id_t    NI_ID           = '0,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic               clk_i,
    input logic               arst_ni,
    axi_grid_sub_ni_if.slave  bus
);

    localparam int TRK_WR = 0;
    localparam int TRK_RD = 1;

    logic     trk_push     [2];
    logic     trk_pop      [2];
    logic     trk_adm      [2];
    logic     trk_nonempty [2];
    grid_id_t trk_push_sid [2];
    grid_id_t trk_head_sid [2];
    axi_id_t  trk_push_id  [2];

    grid_aw_chan_t aw_chan;
    grid_w_chan_t  w_chan;
    grid_ar_chan_t ar_chan;
    grid_b_chan_t  b_chan;
    grid_r_chan_t  r_chan;
    logic          unused_route;

    assign aw_chan = bus.grid_aw_chan_i;
    assign w_chan  = bus.grid_w_chan_i;
    assign ar_chan = bus.grid_ar_chan_i;
    assign b_chan  = bus.axi_b_i;
    assign r_chan  = bus.axi_r_i;

    // Destination fields are trusted to the grid; W routing is not needed at all.
    assign unused_route = ^{bus.grid_aw_did_i, bus.grid_ar_did_i,
                            bus.grid_w_did_i, bus.grid_w_sid_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_trk
        axi_grid_ni_tracker #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .grid_id_t       (grid_id_t),
            .axi_id_t        (axi_id_t)
        ) u_trk (
            .clk_i    (clk_i),
            .arst_ni  (arst_ni),
            .push     (trk_push[gi]),
            .push_sid (trk_push_sid[gi]),
            .push_id  (trk_push_id[gi]),
            .pop      (trk_pop[gi]),
            .adm_id   (trk_push_id[gi]),
            .adm      (trk_adm[gi]),
            .head_sid (trk_head_sid[gi]),
            .nonempty (trk_nonempty[gi])
        );
    end

    // Write request and response
    assign trk_push_sid[TRK_WR] = bus.grid_aw_sid_i;
    assign trk_push_id[TRK_WR]  = aw_chan.id;
    assign trk_push[TRK_WR]     = bus.grid_aw_valid_i & bus.axi_aw_ready_i & trk_adm[TRK_WR];
    assign trk_pop[TRK_WR]      = bus.axi_b_valid_i & bus.grid_b_ready_i & trk_nonempty[TRK_WR];

    assign bus.axi_aw_o        = aw_chan;
    assign bus.axi_aw_valid_o  = bus.grid_aw_valid_i & trk_adm[TRK_WR];
    assign bus.grid_aw_ready_o = bus.axi_aw_ready_i & trk_adm[TRK_WR];

    assign bus.grid_b_chan_o  = b_chan;
    assign bus.grid_b_did_o   = trk_head_sid[TRK_WR];
    assign bus.grid_b_sid_o   = NI_ID;
    assign bus.grid_b_valid_o = bus.axi_b_valid_i & trk_nonempty[TRK_WR];
    assign bus.axi_b_ready_o  = bus.grid_b_ready_i & trk_nonempty[TRK_WR];

    assign bus.axi_w_o        = w_chan;
    assign bus.axi_w_valid_o  = bus.grid_w_valid_i;
    assign bus.grid_w_ready_o = bus.axi_w_ready_i;

    // Read request and response; a burst pops only on its last beat.
    assign trk_push_sid[TRK_RD] = bus.grid_ar_sid_i;
    assign trk_push_id[TRK_RD]  = ar_chan.id;
    assign trk_push[TRK_RD]     = bus.grid_ar_valid_i & bus.axi_ar_ready_i & trk_adm[TRK_RD];
    assign trk_pop[TRK_RD]      = bus.axi_r_valid_i & bus.grid_r_ready_i
                                & trk_nonempty[TRK_RD] & r_chan.last;

    assign bus.axi_ar_o        = ar_chan;
    assign bus.axi_ar_valid_o  = bus.grid_ar_valid_i & trk_adm[TRK_RD];
    assign bus.grid_ar_ready_o = bus.axi_ar_ready_i & trk_adm[TRK_RD];

    assign bus.grid_r_chan_o  = r_chan;
    assign bus.grid_r_did_o   = trk_head_sid[TRK_RD];
    assign bus.grid_r_sid_o   = NI_ID;
    assign bus.grid_r_valid_o = bus.axi_r_valid_i & trk_nonempty[TRK_RD];
    assign bus.axi_r_ready_o  = bus.grid_r_ready_i & trk_nonempty[TRK_RD];

endmodule

// File: doc/axi_grid_sub_ni.md
# axi_grid_sub_ni

Subordinate-side network interface for the AXI grid. It terminates the grid at a node whose ID is `NI_ID` and drives one AXI subordinate. It strips `did`/`sid` from incoming AW/W/AR requests and forwards the AXI payload. It returns B/R responses into the grid, addressed back to the requesting node, by tracking the source ID of every outstanding transaction.

## Interface
- `NI_ID`, `'0`: grid ID of this node; driven on `grid_b_sid_o` and `grid_r_sid_o`.
- `MAX_OUTSTANDING`, 4: maximum outstanding writes, and separately maximum outstanding reads (≥1).
- `grid_id_t`, `axi_default_param_pkg::grid_id_t`: grid node ID type.
- `grid_aw_chan_t`, `grid_w_chan_t`, `grid_b_chan_t`, `grid_ar_chan_t`, `grid_r_chan_t`, package defaults: AXI channel payloads.
  - AW/AR/B/R payloads carry `.id`.
  - R payload carries `.last`.
- `axi_id_t`, `axi_default_param_pkg::axi_id_t`: AXI transaction ID type.

Ports:
- `clk_i` in 1: clock.
- `arst_ni` in 1: reset, asynchronous, active-low.
- `grid_{aw,w,ar}_did_i`, `grid_{aw,w,ar}_sid_i` in `grid_id_t`: request routing fields.
- `grid_{aw,w,ar}_chan_i` in chan_t: request payload.
- `grid_{aw,w,ar}_valid_i` in 1 / `grid_{aw,w,ar}_ready_o` out 1: request handshake.
- `grid_{b,r}_did_o`, `grid_{b,r}_sid_o` out `grid_id_t`: response routing fields.
- `grid_{b,r}_chan_o` out chan_t: response payload.
- `grid_{b,r}_valid_o` out 1 / `grid_{b,r}_ready_i` in 1: response handshake.
- `axi_{aw,w,ar}_o` out chan_t, `axi_{aw,w,ar}_valid_o` out 1, `axi_{aw,w,ar}_ready_i` in 1: AXI subordinate requests.
- `axi_{b,r}_i` in chan_t, `axi_{b,r}_valid_i` in 1, `axi_{b,r}_ready_o` out 1: AXI subordinate responses.

## Operation
- There are two independent trackers, write (AW→B) and read (AR→R). Each tracker holds:
  - `cnt` (0..MAX_OUTSTANDING);
  - `lock_id` (`axi_id_t`);
  - a sid FIFO of depth MAX_OUTSTANDING.
- Request admit condition: `adm = (cnt==0) || (cnt<MAX_OUTSTANDING && chan_i.id==lock_id)`.
  - `axi_aw_valid_o = grid_aw_valid_i & adm`.
  - `grid_aw_ready_o = axi_aw_ready_i & adm`.
  - `axi_aw_o = grid_aw_chan_i`.
  - AR uses the same rules.
- Single-ID lock: the AXI same-ID ordering rule guarantees that responses return in FIFO order.
- On request handshake: push `sid_i`, load `lock_id <= chan_i.id`, increment `cnt`.
- W is a pure combinational pass-through. `did`/`sid` are dropped and nothing is tracked.
- Response path: `grid_b_chan_o = axi_b_i`, `grid_b_did_o = FIFO head`, `grid_b_sid_o = NI_ID`.
  - `grid_b_valid_o = axi_b_valid_i & (cnt!=0)`.
  - `axi_b_ready_o = grid_b_ready_i & (cnt!=0)`.
  - Responses arriving while `cnt==0` stall; they are never forwarded or dropped.
- Pop and decrement on a B handshake. On R, pop only on a handshake with `.last=1`; every beat of a burst carries the same `did`.
- Push and pop in the same cycle: `cnt` unchanged, FIFO pointers both advance.
- `did_i` is not checked; routing correctness belongs to the grid.

## Timing
- Reset: `cnt=0`, FIFO pointers 0, `lock_id='0`. In consequence `grid_b_valid_o`, `grid_r_valid_o`, `axi_b_ready_o` and `axi_r_ready_o` are all 0.
- Request-valid outputs during reset follow `grid_*_valid_i` through `adm`.
- All data paths have zero-cycle latency. State updates on the rising `clk_i` edge after a handshake.
- `adm` depends only on registered state and `chan_i.id`. There is no combinational path from the response side.
  - At `cnt==MAX_OUTSTANDING`, a new request is refused even if a pop occurs in the same cycle.
- After the last pop (`cnt` 1→0), the next cycle admits any ID.
- Reset asserted mid-burst clears all tracking immediately. Outstanding responses are orphaned, and the subordinate must also be reset.

## Structure
- Shared package `axi_default_param_pkg`: `grid_id_t`, `axi_id_t` and the chan typedefs. No new constants.
- One sub-module, `axi_grid_ni_tracker`, instantiated twice (write and read). Parameters: `MAX_OUTSTANDING`, `grid_id_t`, `axi_id_t`.
  - Ports: `push`, `push_sid`, `push_id`, `pop`, `adm_id`, `adm`, `head_sid`, `nonempty`.
- Top level: wiring plus the W pass-through; roughly 150–250 lines total.

## Test plan
- Single write: AW `sid=3, id=5, len=0`, then W, then AXI B `resp=OKAY` → `grid_b` shows `did=3`, `sid=NI_ID`; write `cnt` returns to 0.
- Two writes with `id=2` from `sid=1` then `sid=4`, B returned after both → B handshakes deliver `did=1` then `did=4`.
- Write `id=2` outstanding, then AW `id=7` → `grid_aw_ready_o=0` until the first B handshake, then accepted one cycle later.
- MAX_OUTSTANDING=4: five same-ID ARs with no R → four accepted, fifth stalls. R for AR#1 returned in the same cycle the fifth AR is presented → fifth still refused that cycle, accepted the next.
- AR `sid=6, len=3`, subordinate returns 4 beats → all four `grid_r` beats carry `did=6`; `cnt` decrements only on the `last` beat.
- Reset pulse mid read burst (beat 2 of 4) → `grid_r_valid_o=0` and `axi_r_ready_o=0` immediately; after reset, AR `id=9` is admitted on its first cycle.
